regfile_mc: RTL



---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_mc_if.sv | 29 ++
 rtl/regfile_clr_fsm.sv | 68 ++++++
 rtl/regfile_mc.sv | 86 ++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multicycle datapath register file.
package regfile_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned AW_DEF = 3;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_mc_if.sv
// Datapath-side bus of the register file: write port, two read ports, clear control.
interface regfile_mc_if
  import regfile_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
);

  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          clr_req;
  logic          busy;

  modport master (
    output we3, wa3, wd3, ra1, ra2, clr_req,
    input  rd1, rd2, busy
  );

  modport slave (
    input  we3, wa3, wd3, ra1, ra2, clr_req,
    output rd1, rd2, busy
  );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks every entry once, writing zero, after reset or on request.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam int unsigned   NREGS = 1 << AW;
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;

  // State, pointer and busy flag; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: sweep ends on compare with the last index so AW=1 terminates too.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    unique case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == LAST) begin
          state_d = RUN;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mc.sv
// Multi-ported register file: two combinational reads, one clocked write,
// clear engine, optional write-to-read bypass and hardwired-zero entry 0.
module regfile_mc
  import regfile_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mc_if.slave  bus
);

  localparam int unsigned NREGS = 1 << AW;

  logic [DW-1:0] rf [NREGS];

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  logic          wr_en_c;
  logic [AW-1:0] wr_addr_c;
  logic [DW-1:0] wr_data_c;
  logic [DW-1:0] rd1_c;
  logic [DW-1:0] rd2_c;

  function automatic logic hardwired(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  function automatic logic [DW-1:0] read_port(
    input logic          busy_i,
    input logic [AW-1:0] ra,
    input logic          we,
    input logic [AW-1:0] wa,
    input logic [DW-1:0] wd,
    input logic [DW-1:0] stored
  );
    if (busy_i || hardwired(ra)) return '0;
    if (BYPASS && we && (wa == ra)) return wd;
    return stored;
  endfunction

  regfile_clr_fsm #(.AW(AW)) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Write mux: the clear engine owns the port while sweeping; datapath writes are dropped then.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = bus.wa3;
    wr_data_c = bus.wd3;
    if (clr_we) begin
      wr_en_c   = 1'b1;
      wr_addr_c = clr_addr;
      wr_data_c = '0;
    end else if (bus.we3 && !hardwired(bus.wa3)) begin
      wr_en_c = 1'b1;
    end
    if (!rst_n) wr_en_c = 1'b0;
  end

  // Storage array; contents are only ever zeroed by the clear engine.
  always_ff @(posedge clk) begin
    if (wr_en_c) rf[wr_addr_c] <= wr_data_c;
  end

  // Read ports: masked while clearing, entry 0 forced to zero, same-cycle write forwarded.
  always_comb begin
    rd1_c = read_port(busy, bus.ra1, bus.we3, bus.wa3, bus.wd3, rf[bus.ra1]);
    rd2_c = read_port(busy, bus.ra2, bus.we3, bus.wa3, bus.wd3, rf[bus.ra2]);
  end

  assign bus.rd1  = rd1_c;
  assign bus.rd2  = rd2_c;
  assign bus.busy = busy;

endmodule
